// File: rtl/riscv_rf_pkg.sv
// Shared constants and types for the integer register file and its scoreboard.
package riscv_rf_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  typedef logic [RF_ADDR_W-1:0] reg_addr_t;
  typedef logic [RF_DATA_W-1:0] reg_data_t;

  localparam reg_data_t ZERO_WORD    = '0;
  localparam reg_addr_t ZERO_REG     = '0;
  localparam logic      WRITE_ENABLE = 1'b1;

endpackage : riscv_rf_pkg

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard for the register file.
// One busy bit per register. Priority within a cycle, from lowest to highest:
// writeback clear, then issue set (the new producer owns the register), then flush.
// Register 0 is never busy.
module rf_scoreboard #(
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 2**ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iss_valid,
  input  logic [ADDR_W-1:0]   iss_rd,
  input  logic                flush,
  input  logic [NUM_REGS-1:0] wb_clr,
  output logic [NUM_REGS-1:0] busy,
  output logic                iss_ready,
  output logic                iss_fire
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Issue acceptance: free destination, or x0, regardless of iss_valid.
  always_comb begin
    iss_ready = ~busy_q[iss_rd] | (iss_rd == '0);
    iss_fire  = iss_valid & iss_ready & (iss_rd != '0) & ~flush;
  end

  // Next busy vector: clear on writeback, set on issue, flush wipes everything.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    busy_d = busy_q & ~wb_clr;
    if (iss_fire) begin
      busy_d[iss_rd] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  // Busy state register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the values from before the edge, independent of statement order.
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule : rf_scoreboard

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with integrated issue scoreboard.
// NUM_RD combinational read ports, NUM_WR synchronous write ports (higher
// index wins on an address collision), x0 hard-wired to zero and never busy.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// to the read ports; without it a write is visible the cycle after the edge.
module regfile_mp_sb
  import riscv_rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic                       iss_valid,
  input  logic [ADDR_W-1:0]          iss_rd,
  output logic                       iss_ready,
  input  logic                       flush
);

  localparam int NUM_REGS = 2**ADDR_W;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wb_clr;
  logic [NUM_REGS-1:0] busy;
  logic                iss_fire;

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .flush     (flush),
    .wb_clr    (wb_clr),
    .busy      (busy),
    .iss_ready (iss_ready),
    .iss_fire  (iss_fire)
  );

  // Write-port merge: ascending port order so the highest index wins; x0 writes dropped.
  always_comb begin
    regs_d = regs_q;
    wb_clr = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_en[p] == WRITE_ENABLE && wr_addr[p*ADDR_W +: ADDR_W] != '0) begin
        regs_d[wr_addr[p*ADDR_W +: ADDR_W]] = wr_data[p*DATA_W +: DATA_W];
        wb_clr[wr_addr[p*ADDR_W +: ADDR_W]] = 1'b1;
      end
    end
    regs_d[0] = '0;
  end

  // Storage array; cleared as a whole by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the array is reset explicitly because reads after reset must
      // return zero; this forces flops rather than a RAM macro, which is fine
      // at register-file size.
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read muxes, with optional same-cycle forwarding from the write ports.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (rd_addr[k*ADDR_W +: ADDR_W] != '0) begin
        rd_data[k*DATA_W +: DATA_W] = regs_q[rd_addr[k*ADDR_W +: ADDR_W]];
        rd_busy[k]                  = busy[rd_addr[k*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
        // A new producer claiming the register this cycle takes precedence:
        // the reader then sees the stored view rather than the retiring value.
        if (!(iss_fire && iss_rd == rd_addr[k*ADDR_W +: ADDR_W])) begin
          for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p] == WRITE_ENABLE &&
                wr_addr[p*ADDR_W +: ADDR_W] == rd_addr[k*ADDR_W +: ADDR_W]) begin
              rd_data[k*DATA_W +: DATA_W] = wr_data[p*DATA_W +: DATA_W];
              rd_busy[k]                  = 1'b0;
            end
          end
        end
`endif
      end
    end
  end

endmodule : regfile_mp_sb
